// File: rtl/vga_mem_arbiter_if.sv
// Request/grant and RAM-side signals shared between the VGA memory arbiter and its clients.
// master = requesters plus RAM model, slave = the arbiter itself.
interface vga_mem_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;

  logic              draw_req;
  logic              draw_we;
  logic [ADDR_W-1:0] draw_addr;
  logic [DATA_W-1:0] draw_wdata;
  logic              draw_gnt;
  logic              draw_rvalid;
  logic [DATA_W-1:0] draw_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output disp_req, disp_addr, draw_req, draw_we, draw_addr, draw_wdata, mem_rdata,
    input  disp_gnt, disp_rvalid, disp_rdata, draw_gnt, draw_rvalid, draw_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  disp_req, disp_addr, draw_req, draw_we, draw_addr, draw_wdata, mem_rdata,
    output disp_gnt, disp_rvalid, disp_rdata, draw_gnt, draw_rvalid, draw_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Single-port framebuffer arbiter: display wins during the active region, draw wins in
// blanking or once it has starved for WAIT_MAX cycles. One access per cycle, fully pipelined.
module vga_mem_arbiter #(
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 12,
  parameter int WAIT_MAX    = 16,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 783,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 514
) (
  input  logic                clk_pixel,
  input  logic                reset,
  input  logic [9:0]          H_Count_Value,
  input  logic [9:0]          V_Count_Value,
  vga_mem_arbiter_if.slave    bus
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [9:0] H_LO = 10'(H_ACT_START);
  localparam logic [9:0] H_HI = 10'(H_ACT_END);
  localparam logic [9:0] V_LO = 10'(V_ACT_START);
  localparam logic [9:0] V_HI = 10'(V_ACT_END);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(WAIT_MAX);

  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_DRAW} tag_t;

  logic              active;
  logic              force_draw;
  logic              disp_gnt;
  logic              draw_gnt;

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  tag_t              tag_mem_q, tag_mem_d;
  tag_t              tag_rd_q, tag_rd_d;

  assign active = (H_Count_Value >= H_LO) && (H_Count_Value <= H_HI) &&
                  (V_Count_Value >= V_LO) && (V_Count_Value <= V_HI);
  assign force_draw = (wait_cnt_q == WAIT_SAT);

  always_comb begin
    disp_gnt = 1'b0;
    draw_gnt = 1'b0;
    if (!reset) begin
      if (bus.disp_req && bus.draw_req) begin
        if (force_draw || !active) draw_gnt = 1'b1;
        else                       disp_gnt = 1'b1;
      end else if (bus.disp_req) begin
        disp_gnt = 1'b1;
      end else if (bus.draw_req) begin
        draw_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    wait_cnt_d  = '0;
    mem_en_d    = disp_gnt | draw_gnt;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tag_mem_d   = TAG_NONE;
    tag_rd_d    = tag_mem_q;
    if (bus.draw_req && !draw_gnt)
      wait_cnt_d = force_draw ? wait_cnt_q : wait_cnt_q + 1'b1;
    if (disp_gnt) begin
      mem_we_d   = 1'b0;
      mem_addr_d = bus.disp_addr;
      tag_mem_d  = TAG_DISP;
    end else if (draw_gnt) begin
      mem_we_d    = bus.draw_we;
      mem_addr_d  = bus.draw_addr;
      mem_wdata_d = bus.draw_wdata;
      tag_mem_d   = bus.draw_we ? TAG_NONE : TAG_DRAW;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      wait_cnt_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tag_mem_q   <= TAG_NONE;
      tag_rd_q    <= TAG_NONE;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tag_mem_q   <= tag_mem_d;
      tag_rd_q    <= tag_rd_d;
    end
  end

  // Outputs are masked by reset so an access granted just before reset never reaches the RAM.
  assign bus.disp_gnt    = disp_gnt;
  assign bus.draw_gnt    = draw_gnt;
  assign bus.mem_en      = mem_en_q & ~reset;
  assign bus.mem_we      = mem_we_q & ~reset;
  assign bus.mem_addr    = reset ? '0 : mem_addr_q;
  assign bus.mem_wdata   = reset ? '0 : mem_wdata_q;
  assign bus.disp_rvalid = (tag_rd_q == TAG_DISP) && !reset;
  assign bus.draw_rvalid = (tag_rd_q == TAG_DRAW) && !reset;
  assign bus.disp_rdata  = bus.mem_rdata;
  assign bus.draw_rdata  = bus.mem_rdata;

endmodule
